// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the MEM-stage to external 16-bit SRAM bridge.
// Pure declarations: no latency, no flow control.
package arm_mem_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LO   = 3'd1,
      HI   = 3'd2,
      WAIT = 3'd3,
      DONE = 3'd4
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
   localparam int          SRAM_AW_DEF   = 18;

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM access into low/high half-word SRAM cycles plus wait states.
// ready is low for ACCESS_CYCLES cycles from the request; the pipeline freezes while it is low.
module sram_controller
   import arm_mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEF,
   parameter int          ACCESS_CYCLES = 6,
   parameter int          SRAM_AW       = SRAM_AW_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_we_n
);

   localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

   state_t             state_q, state_d;
   op_t                op_q, op_d;
   logic [3:0]         count_q, count_d;
   logic [SRAM_AW-2:0] word_q, word_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        read_data_q, read_data_d;
   logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
   logic [15:0]        dq_out_q, dq_out_d;
   logic               dq_oe_q, dq_oe_d;
   logic               we_n_q, we_n_d;

   logic               req;
   logic               op_is_wr;
   logic [31:0]        offset;
   logic [SRAM_AW-2:0] word_addr;
   logic               unused_addr_bits;

   assign req              = wr_en | rd_en;
   assign op_is_wr         = (op_q == OP_WR);
   assign offset           = address - BASE_ADDR;
   // Word index wraps modulo the SRAM size; byte-lane bits are dropped.
   assign word_addr        = offset[SRAM_AW:2];
   assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      count_d     = count_q;
      word_d      = word_q;
      wdata_d     = wdata_q;
      read_data_d = read_data_q;
      sram_addr_d = sram_addr_q;
      dq_out_d    = dq_out_q;
      dq_oe_d     = dq_oe_q;
      we_n_d      = we_n_q;

      case (state_q)
         IDLE: begin
            if (req) begin
               op_d        = wr_en ? OP_WR : OP_RD;
               word_d      = word_addr;
               wdata_d     = write_data;
               count_d     = 4'd1;
               state_d     = LO;
               sram_addr_d = {word_addr, 1'b0};
               dq_out_d    = write_data[15:0];
               dq_oe_d     = wr_en;
               we_n_d      = ~wr_en;
            end
         end
         LO: begin
            if (!op_is_wr) read_data_d[15:0] = sram_dq_in;
            count_d     = count_q + 4'd1;
            state_d     = HI;
            sram_addr_d = {word_q, 1'b1};
            dq_out_d    = wdata_q[31:16];
            dq_oe_d     = op_is_wr;
            we_n_d      = ~op_is_wr;
         end
         HI: begin
            if (!op_is_wr) read_data_d[31:16] = sram_dq_in;
            count_d = count_q + 4'd1;
            state_d = (count_q == LAST_CNT) ? DONE : WAIT;
            dq_oe_d = 1'b0;
            we_n_d  = 1'b1;
         end
         WAIT: begin
            count_d = count_q + 4'd1;
            if (count_q == LAST_CNT) state_d = DONE;
         end
         DONE: begin
            count_d = 4'd0;
            state_d = IDLE;
         end
         default: begin
            count_d = 4'd0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= OP_RD;
         count_q     <= 4'd0;
         word_q      <= '0;
         wdata_q     <= 32'd0;
         read_data_q <= 32'd0;
         sram_addr_q <= '0;
         dq_out_q    <= 16'd0;
         dq_oe_q     <= 1'b0;
         we_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         count_q     <= count_d;
         word_q      <= word_d;
         wdata_q     <= wdata_d;
         read_data_q <= read_data_d;
         sram_addr_q <= sram_addr_d;
         dq_out_q    <= dq_out_d;
         dq_oe_q     <= dq_oe_d;
         we_n_q      <= we_n_d;
      end
   end

   // The request is visible combinationally so the freeze starts in the request cycle.
   assign ready       = (state_q == DONE) || ((state_q == IDLE) && !req);
   assign read_data   = read_data_q;
   assign sram_addr   = sram_addr_q;
   assign sram_dq_out = dq_out_q;
   assign sram_dq_oe  = dq_oe_q;
   assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (6 and 3 access cycles), each with its own SRAM.
module tb_sram_controller;

   logic        clk;
   logic        rst;
   logic [1:0]  wr_en, rd_en, ready, sram_dq_oe, sram_we_n;
   logic [31:0] address     [2];
   logic [31:0] write_data  [2];
   logic [31:0] read_data   [2];
   logic [17:0] sram_addr   [2];
   logic [15:0] sram_dq_out [2];
   logic [15:0] sram_dq_in  [2];

   bit   [15:0] sram    [2][0:262143];
   bit   [15:0] exp_mem [2][0:262143];
   int          wr_cnt  [2];

   int          checks;
   int          errors;

   // reference model state: access in progress and its cycle index
   bit          busy   [2];
   int          k      [2];
   bit          m_wr   [2];
   logic [16:0] m_a    [2];
   logic [31:0] m_wd   [2];
   logic [31:0] exp_rd [2];
   bit          exp_ready;
   bit          xfer;

   sram_controller #(.ACCESS_CYCLES(6)) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en[0]), .rd_en(rd_en[0]),
      .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
      .ready(ready[0]), .sram_addr(sram_addr[0]), .sram_dq_out(sram_dq_out[0]),
      .sram_dq_oe(sram_dq_oe[0]), .sram_dq_in(sram_dq_in[0]), .sram_we_n(sram_we_n[0])
   );

   sram_controller #(.ACCESS_CYCLES(3)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en[1]), .rd_en(rd_en[1]),
      .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
      .ready(ready[1]), .sram_addr(sram_addr[1]), .sram_dq_out(sram_dq_out[1]),
      .sram_dq_oe(sram_dq_oe[1]), .sram_dq_in(sram_dq_in[1]), .sram_we_n(sram_we_n[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // async SRAM: combinational read, write taken while we_n is low
   assign sram_dq_in[0] = sram[0][sram_addr[0]];
   assign sram_dq_in[1] = sram[1][sram_addr[1]];

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (sram_we_n[i] === 1'b0) begin
            sram[i][sram_addr[i]] <= sram_dq_out[i];
            wr_cnt[i]             <= wr_cnt[i] + 1;
         end
      end
   end

   function automatic int ac_of(input int i);
      return (i == 0) ? 6 : 3;
   endfunction

   function automatic logic [16:0] word_of(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - 32'd1024;
      return 17'((off / 4) % 131072);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model: an access occupies cycles 0..AC (ready only in the last); halves move in cycles 1 and 2.
   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            busy[i]   <= 1'b0;
            k[i]      <= 0;
            exp_rd[i] <= 32'd0;
         end else if (!busy[i]) begin
            if (wr_en[i] || rd_en[i]) begin
               busy[i] <= 1'b1;
               k[i]    <= 1;
               m_wr[i] <= wr_en[i];
               m_a[i]  <= word_of(address[i]);
               m_wd[i] <= write_data[i];
               if (wr_en[i]) begin
                  exp_mem[i][{word_of(address[i]), 1'b0}] <= write_data[i][15:0];
                  exp_mem[i][{word_of(address[i]), 1'b1}] <= write_data[i][31:16];
               end else begin
                  exp_rd[i] <= {exp_mem[i][{word_of(address[i]), 1'b1}],
                                exp_mem[i][{word_of(address[i]), 1'b0}]};
               end
            end
         end else if (k[i] == ac_of(i)) begin
            busy[i] <= 1'b0;
         end else begin
            k[i] <= k[i] + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            exp_ready = busy[i] ? (k[i] == ac_of(i)) : !(wr_en[i] || rd_en[i]);
            xfer      = busy[i] && (k[i] == 1 || k[i] == 2);
            check($sformatf("dut%0d ready", i), 64'(ready[i]), 64'(exp_ready));
            check($sformatf("dut%0d we_n", i), 64'(sram_we_n[i]), 64'(!(xfer && m_wr[i])));
            check($sformatf("dut%0d dq_oe", i), 64'(sram_dq_oe[i]), 64'(xfer && m_wr[i]));
            if (xfer)
               check($sformatf("dut%0d sram_addr", i), 64'(sram_addr[i]), 64'({m_a[i], k[i] == 2}));
            if (xfer && m_wr[i])
               check($sformatf("dut%0d dq_out", i), 64'(sram_dq_out[i]),
                     64'((k[i] == 2) ? m_wd[i][31:16] : m_wd[i][15:0]));
            if (exp_ready)
               check($sformatf("dut%0d read_data", i), 64'(read_data[i]), 64'(exp_rd[i]));
         end
      end
   end

   task automatic access(input int i, input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] wd, output int lo, output int mask,
                         output logic [31:0] rdat);
      bit done;
      done = 1'b0;
      lo   = 0;
      mask = 0;
      rdat = 32'd0;
      @(posedge clk);
      #1;
      wr_en[i]      = wr;
      rd_en[i]      = rd;
      address[i]    = addr;
      write_data[i] = wd;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (sram_we_n[i] === 1'b0) mask |= (1 << c);
         if (ready[i] === 1'b1) begin
            done = 1'b1;
            rdat = read_data[i];
         end else begin
            lo++;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL access timeout dut%0d: ready stayed 0, required 1 within 40 cycles", i);
      end
      @(posedge clk);
      #1;
      wr_en[i] = 1'b0;
      rd_en[i] = 1'b0;
   endtask

   int          lo, mask, wc;
   logic [31:0] rdat, r0, r1;
   logic [7:0]  pat;

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      wr_en  = 2'b00;
      rd_en  = 2'b00;
      for (int i = 0; i < 2; i++) begin
         address[i]    = 32'd0;
         write_data[i] = 32'd0;
      end

      repeat (3) @(negedge clk);
      #1;
      check("reset ready", 64'(ready), 64'(2'b11));
      check("reset we_n", 64'(sram_we_n), 64'(2'b11));
      check("reset dq_oe", 64'(sram_dq_oe), 64'(2'b00));
      check("reset read_data", 64'(read_data[0]), 64'(32'd0));
      check("reset sram_addr", 64'(sram_addr[0]), 64'(18'd0));
      #1 rst = 1'b0;

      access(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lo, mask, rdat);
      check("write ready-low cycles", 64'(lo), 64'(6));
      check("write we_n low cycles", 64'(mask), 64'(32'h6));
      check("write sram[0]", 64'(sram[0][0]), 64'(16'hBEEF));
      check("write sram[1]", 64'(sram[0][1]), 64'(16'hDEAD));

      access(0, 1'b0, 1'b1, 32'd1024, 32'd0, lo, mask, rdat);
      check("read ready-low cycles", 64'(lo), 64'(6));
      check("read we_n never low", 64'(mask), 64'(0));
      check("read data", 64'(rdat), 64'(32'hDEADBEEF));

      access(0, 1'b1, 1'b0, 32'd1028, 32'h11112222, lo, mask, rdat);
      check("map 1028 lo", 64'(sram[0][2]), 64'(16'h2222));
      check("map 1028 hi", 64'(sram[0][3]), 64'(16'h1111));
      access(0, 1'b1, 1'b0, 32'd525308, 32'hAAAA5555, lo, mask, rdat);
      check("map top lo", 64'(sram[0][18'h3FFFE]), 64'(16'h5555));
      check("map top hi", 64'(sram[0][18'h3FFFF]), 64'(16'hAAAA));
      access(0, 1'b1, 1'b0, 32'd525312, 32'hCAFEF00D, lo, mask, rdat);
      check("map wrap lo", 64'(sram[0][0]), 64'(16'hF00D));
      check("map wrap hi", 64'(sram[0][1]), 64'(16'hCAFE));

      access(0, 1'b1, 1'b1, 32'd1028, 32'h12345678, lo, mask, rdat);
      check("both wr/rd lo", 64'(sram[0][2]), 64'(16'h5678));
      check("both wr/rd hi", 64'(sram[0][3]), 64'(16'h1234));
      check("both wr/rd we_n cycles", 64'(mask), 64'(32'h6));
      check("both wr/rd read_data kept", 64'(read_data[0]), 64'(32'hDEADBEEF));

      // reset during the wait states of a write
      @(posedge clk);
      #1;
      wr_en[0]      = 1'b1;
      address[0]    = 32'd1040;
      write_data[0] = 32'h0BADF00D;
      repeat (4) @(negedge clk);
      check("busy before reset", 64'(ready[0]), 64'(0));
      #2;
      rst      = 1'b1;
      wr_en[0] = 1'b0;
      #1;
      check("mid reset ready", 64'(ready[0]), 64'(1));
      check("mid reset we_n", 64'(sram_we_n[0]), 64'(1));
      check("mid reset dq_oe", 64'(sram_dq_oe[0]), 64'(0));
      check("mid reset read_data", 64'(read_data[0]), 64'(32'd0));
      check("mid reset sram_addr", 64'(sram_addr[0]), 64'(18'd0));
      wc = wr_cnt[0];
      repeat (3) @(negedge clk);
      check("no writes under reset", 64'(wr_cnt[0]), 64'(wc));
      check("total half-word writes", 64'(wr_cnt[0]), 64'(12));
      #2 rst = 1'b0;

      access(0, 1'b0, 1'b1, 32'd1040, 32'd0, lo, mask, rdat);
      check("read after reset", 64'(rdat), 64'(32'h0BADF00D));

      // three-cycle instance
      access(1, 1'b1, 1'b0, 32'd1024, 32'h01020304, lo, mask, rdat);
      check("ac3 write ready-low cycles", 64'(lo), 64'(3));
      access(1, 1'b1, 1'b0, 32'd1028, 32'h0A0B0C0D, lo, mask, rdat);
      check("ac3 write we_n cycles", 64'(mask), 64'(32'h6));

      @(posedge clk);
      #1;
      rd_en[1]   = 1'b1;
      address[1] = 32'd1024;
      pat = 8'd0;
      r0  = 32'd0;
      r1  = 32'd0;
      for (int idx = 0; idx < 8; idx++) begin
         @(negedge clk);
         pat[idx] = ready[1];
         if (ready[1] && idx == 3) r0 = read_data[1];
         if (ready[1] && idx == 7) r1 = read_data[1];
         if (idx == 3) begin
            @(posedge clk);
            #1 address[1] = 32'd1028;
         end
      end
      @(posedge clk);
      #1 rd_en[1] = 1'b0;
      check("ac3 ready pattern", 64'(pat), 64'(8'b1000_1000));
      check("ac3 first read", 64'(r0), 64'(32'h01020304));
      check("ac3 second read", 64'(r1), 64'(32'h0A0B0C0D));

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at 500000, required finish earlier");
      $fatal(1, "watchdog");
   end

endmodule
